// File: rtl/uop_dispatch_controller.sv
// Micro-op dispatch controller: issues the queue-head op to its execution unit,
// holds the enable until done, pops the queue, and keeps per-unit retire counts.
module uop_dispatch_controller #(
  parameter int UOP_W       = 32,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             cclk,
  input  logic             rst,
  input  logic [UOP_W-1:0] iq_uop,
  input  logic             iq_ip,
  output logic             iq_pop,
  input  logic             stall,
  output logic             alu_en,
  input  logic             alu_dn,
  output logic             pfcu_en,
  input  logic             pfcu_dn,
  output logic             lsu_en,
  input  logic             lsu_dn,
  output logic             busy,
  output logic             err_illegal,
  output logic             hang,
  output logic [CNT_W-1:0] cnt_alu,
  output logic [CNT_W-1:0] cnt_pfcu,
  output logic [CNT_W-1:0] cnt_lsu,
  output logic [CNT_W-1:0] cnt_ill
);

  localparam logic [2:0] U_ALU  = 3'b100;
  localparam logic [2:0] U_PFCU = 3'b110;
  localparam logic [2:0] U_LSU  = 3'b010;
  localparam int         TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_POP} state_t;

  state_t          r_state, w_next;
  logic [2:0]      r_unit;
  logic [TW-1:0]   r_timer;
  logic            r_hang;
  logic            w_start;
  logic            w_done;
  logic [2:0]      w_head;
  logic            w_unused_uop_hi;

  function automatic logic is_legal(input logic [2:0] u);
    return (u == U_ALU) || (u == U_PFCU) || (u == U_LSU);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign w_head          = iq_uop[2:0];
  assign w_unused_uop_hi = ^iq_uop[UOP_W-1:3];
  assign w_start         = iq_ip & ~stall;

  // Only the latched unit's done counts; the others are ignored.
  always_comb begin
    w_done = 1'b0;
    case (r_unit)
      U_ALU:   w_done = alu_dn;
      U_PFCU:  w_done = pfcu_dn;
      U_LSU:   w_done = lsu_dn;
      default: w_done = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    alu_en      = 1'b0;
    pfcu_en     = 1'b0;
    lsu_en      = 1'b0;
    iq_pop      = 1'b0;
    err_illegal = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: if (w_start) w_next = is_legal(w_head) ? S_EXEC : S_POP;
      S_EXEC: begin
        alu_en  = (r_unit == U_ALU);
        pfcu_en = (r_unit == U_PFCU);
        lsu_en  = (r_unit == U_LSU);
        if (w_done) w_next = S_POP;
      end
      S_POP: begin
        iq_pop      = 1'b1;
        err_illegal = ~is_legal(r_unit);
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_unit   <= '0;
      r_timer  <= '0;
      r_hang   <= 1'b0;
      cnt_alu  <= '0;
      cnt_pfcu <= '0;
      cnt_lsu  <= '0;
      cnt_ill  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_start) begin
        r_unit  <= w_head;
        r_timer <= '0;
      end
      // Timer parks at its last value; the hung op keeps its enable.
      if (r_state == S_EXEC && !w_done) begin
        if (r_timer == TLAST) r_hang  <= 1'b1;
        else                  r_timer <= r_timer + TW'(1);
      end
      if (r_state == S_POP) begin
        case (r_unit)
          U_ALU:   cnt_alu  <= sat_inc(cnt_alu);
          U_PFCU:  cnt_pfcu <= sat_inc(cnt_pfcu);
          U_LSU:   cnt_lsu  <= sat_inc(cnt_lsu);
          default: cnt_ill  <= sat_inc(cnt_ill);
        endcase
      end
    end
  end

  assign hang = r_hang;

endmodule

// File: tb/tb_uop_dispatch_controller.sv
// Directed bench for uop_dispatch_controller with a short hang timeout and
// 2-bit counters so saturation can be reached.
module tb_uop_dispatch_controller;

  localparam int UOP_W = 32;
  localparam int CNT_W = 2;
  localparam int TOUT  = 8;

  logic             cclk = 1'b0;
  logic             rst;
  logic [UOP_W-1:0] iq_uop;
  logic             iq_ip, stall, alu_dn, pfcu_dn, lsu_dn;
  logic             iq_pop, alu_en, pfcu_en, lsu_en, busy, err_illegal, hang;
  logic [CNT_W-1:0] cnt_alu, cnt_pfcu, cnt_lsu, cnt_ill;

  int n_chk  = 0;
  int n_fail = 0;

  uop_dispatch_controller #(.UOP_W(UOP_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TOUT)) dut (
    .cclk(cclk), .rst(rst), .iq_uop(iq_uop), .iq_ip(iq_ip), .iq_pop(iq_pop),
    .stall(stall), .alu_en(alu_en), .alu_dn(alu_dn), .pfcu_en(pfcu_en),
    .pfcu_dn(pfcu_dn), .lsu_en(lsu_en), .lsu_dn(lsu_dn), .busy(busy),
    .err_illegal(err_illegal), .hang(hang), .cnt_alu(cnt_alu),
    .cnt_pfcu(cnt_pfcu), .cnt_lsu(cnt_lsu), .cnt_ill(cnt_ill)
  );

  always #5 cclk = ~cclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  // {alu_en, pfcu_en, lsu_en, iq_pop}
  function automatic logic [31:0] ctl();
    return 32'({alu_en, pfcu_en, lsu_en, iq_pop});
  endfunction

  initial begin
    rst = 1'b0; iq_uop = '0; iq_ip = 1'b0; stall = 1'b0;
    alu_dn = 1'b0; pfcu_dn = 1'b0; lsu_dn = 1'b0;
    tick(); tick();
    chk("rst_ctl",  ctl(), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hang", 32'(hang), 0);
    chk("rst_cnt",  32'({cnt_alu, cnt_pfcu, cnt_lsu, cnt_ill}), 0);
    rst = 1'b1;

    // ALU op, done on second EXEC cycle
    iq_uop = 32'h4; iq_ip = 1'b1;
    tick(); chk("t1_exec1", ctl(), 4'b1000); chk("t1_busy", 32'(busy), 1);
    tick(); chk("t1_exec2", ctl(), 4'b1000); alu_dn = 1'b1;
    tick(); chk("t1_pop", ctl(), 4'b0001); alu_dn = 1'b0; iq_ip = 1'b0;
    tick(); chk("t1_idle", ctl(), 0); chk("t1_cnt_alu", 32'(cnt_alu), 1);

    // Back-to-back PFCU then LSU
    iq_uop = 32'h6; iq_ip = 1'b1;
    tick(); chk("t2_pfcu_exec", ctl(), 4'b0100); pfcu_dn = 1'b1;
    tick(); chk("t2_pfcu_pop", ctl(), 4'b0001); pfcu_dn = 1'b0; iq_uop = 32'h2;
    tick(); chk("t2_gap", ctl(), 0); chk("t2_cnt_pfcu", 32'(cnt_pfcu), 1);
    tick(); chk("t2_lsu_exec", ctl(), 4'b0010); lsu_dn = 1'b1;
    tick(); chk("t2_lsu_pop", ctl(), 4'b0001); lsu_dn = 1'b0; iq_ip = 1'b0;
    tick(); chk("t2_cnt_lsu", 32'(cnt_lsu), 1);

    // Illegal op, then a legal ALU op
    iq_uop = 32'h7; iq_ip = 1'b1;
    tick(); chk("t3_pop", ctl(), 4'b0001); chk("t3_err", 32'(err_illegal), 1);
    iq_uop = 32'h4;
    tick(); chk("t3_err_clr", 32'(err_illegal), 0); chk("t3_cnt_ill", 32'(cnt_ill), 1);
    tick(); chk("t3_alu_exec", ctl(), 4'b1000); alu_dn = 1'b1;
    tick(); chk("t3_alu_pop", ctl(), 4'b0001); alu_dn = 1'b0; iq_ip = 1'b0;
    tick(); chk("t3_cnt_alu", 32'(cnt_alu), 2);

    // Stall holds issue; stall in EXEC and a foreign done do not abort
    iq_uop = 32'h4; iq_ip = 1'b1; stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("t5_stalled", 32'({busy, ctl()}), 0);
    end
    stall = 1'b0;
    tick(); chk("t5_issue", ctl(), 4'b1000);
    stall = 1'b1; lsu_dn = 1'b1;
    tick(); chk("t5_hold", ctl(), 4'b1000);
    lsu_dn = 1'b0; alu_dn = 1'b1;
    tick(); chk("t5_pop", ctl(), 4'b0001); alu_dn = 1'b0; iq_ip = 1'b0; stall = 1'b0;
    tick(); chk("t5_cnt_alu", 32'(cnt_alu), 3);

    // Counter saturates at all-ones
    iq_ip = 1'b1;
    tick(); alu_dn = 1'b1;
    tick(); alu_dn = 1'b0; iq_ip = 1'b0;
    tick(); chk("sat_cnt_alu", 32'(cnt_alu), 3);

    // Hung LSU op
    iq_uop = 32'h2; iq_ip = 1'b1;
    for (int i = 1; i <= TOUT; i++) tick();
    chk("t4_no_hang_yet", 32'(hang), 0); chk("t4_en8", ctl(), 4'b0010);
    tick(); chk("t4_hang", 32'(hang), 1); chk("t4_en9", ctl(), 4'b0010);
    tick(); tick(); chk("t4_still_en", ctl(), 4'b0010);
    lsu_dn = 1'b1;
    tick(); chk("t4_pop", ctl(), 4'b0001); chk("t4_hang_pop", 32'(hang), 1);
    lsu_dn = 1'b0; iq_ip = 1'b0;
    tick(); chk("t4_cnt_lsu", 32'(cnt_lsu), 2); chk("t4_hang_sticky", 32'(hang), 1);

    // Reset in the middle of an op
    iq_uop = 32'h6; iq_ip = 1'b1;
    tick(); chk("t6_exec", ctl(), 4'b0100);
    #3 rst = 1'b0;
    #1 chk("t6_async_ctl", ctl(), 0);
    chk("t6_cnt", 32'({cnt_alu, cnt_pfcu, cnt_lsu, cnt_ill}), 0);
    chk("t6_hang", 32'(hang), 0);
    tick(); chk("t6_no_pop", ctl(), 0);
    rst = 1'b1;
    tick(); chk("t6_reissue", ctl(), 4'b0100); pfcu_dn = 1'b1;
    tick(); chk("t6_pop", ctl(), 4'b0001); pfcu_dn = 1'b0; iq_ip = 1'b0;
    tick(); chk("t6_cnt_pfcu", 32'(cnt_pfcu), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
